// File: rtl/blake2s_pkg.sv
// rtl/blake2s_pkg.sv - shared types and constants for the BLAKE2s compression controller
package blake2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int BLAKE2S_MAX_ROUNDS = 10;
  localparam int ROUND_W            = 4;

  localparam logic MODE_COL  = 1'b0;
  localparam logic MODE_DIAG = 1'b1;

endpackage

// File: rtl/blake2s_round_ctrl.sv
// rtl/blake2s_round_ctrl.sv - block sequencing FSM for the BLAKE2s round schedule and G datapath
module blake2s_round_ctrl
  import blake2s_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int G_LATENCY  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               blk_valid,
  input  logic               blk_last,
  output logic               blk_ready,
  input  logic               abort,
  output logic               load,
  output logic               v_init,
  output logic               last_flag,
  output logic [ROUND_W-1:0] round,
  output logic               mode,
  output logic               g_en,
  output logic               h_update,
  output logic               busy,
  output logic               done
);

  localparam int HALF_ROUNDS = 2 * NUM_ROUNDS;
  localparam int HR_W        = ROUND_W + 1;
  localparam int LAT_W       = 2;

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > BLAKE2S_MAX_ROUNDS) begin : g_bad_num_rounds
    $error("blake2s_round_ctrl: NUM_ROUNDS out of range 1..10");
  end
  if (G_LATENCY < 1 || G_LATENCY > 4) begin : g_bad_g_latency
    $error("blake2s_round_ctrl: G_LATENCY out of range 1..4");
  end

  state_e            state_q;
  logic [HR_W-1:0]   hr_q;    // half-round index: round in the upper bits, mode in bit 0
  logic [LAT_W-1:0]  lat_q;
  logic              last_q;
  logic              half_done;
  logic              last_half;

  assign half_done = (lat_q == LAT_W'(G_LATENCY - 1));
  assign last_half = (hr_q == HR_W'(HALF_ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hr_q    <= '0;
      lat_q   <= '0;
      last_q  <= 1'b0;
    end else if (state_q != ST_IDLE && abort) begin
      state_q <= ST_IDLE;
      hr_q    <= '0;
      lat_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            last_q  <= blk_last;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          hr_q    <= '0;
          lat_q   <= '0;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          if (half_done) begin
            lat_q <= '0;
            if (last_half) begin
              hr_q    <= '0;
              state_q <= ST_FINAL;
            end else begin
              hr_q <= hr_q + 1'b1;
            end
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_FINAL: state_q <= ST_DONE;
        ST_DONE: begin
          last_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign load      = (state_q == ST_INIT);
  assign v_init    = (state_q == ST_INIT);
  assign g_en      = (state_q == ST_ROUND) && half_done;
  // A cancel landing on FINAL/DONE must keep the chaining value and completion untouched
  assign h_update  = (state_q == ST_FINAL) && !abort;
  assign done      = (state_q == ST_DONE) && !abort;
  assign last_flag = last_q;
  assign round     = hr_q[HR_W-1:1];
  assign mode      = hr_q[0] ? MODE_DIAG : MODE_COL;

endmodule

// File: tb/tb_blake2s_round_ctrl.sv
// tb/tb_blake2s_round_ctrl.sv - scoreboard bench for blake2s_round_ctrl (two parameter sets)
module tb_blake2s_round_ctrl;

  typedef struct {
    int inst;
    int kind;  // 0 load, 1 g_en, 2 h_update, 3 done
    int cyc;
    int rnd;
    int md;
    int lf;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [1:0]      blk_valid, blk_last, abort;
  logic [1:0]      blk_ready, load, v_init, last_flag, mode, g_en, h_update, busy, done;
  logic [1:0][3:0] round;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];

  blake2s_round_ctrl #(.NUM_ROUNDS(10), .G_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid[0]), .blk_last(blk_last[0]),
    .blk_ready(blk_ready[0]), .abort(abort[0]), .load(load[0]), .v_init(v_init[0]),
    .last_flag(last_flag[0]), .round(round[0]), .mode(mode[0]), .g_en(g_en[0]),
    .h_update(h_update[0]), .busy(busy[0]), .done(done[0])
  );

  blake2s_round_ctrl #(.NUM_ROUNDS(2), .G_LATENCY(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid[1]), .blk_last(blk_last[1]),
    .blk_ready(blk_ready[1]), .abort(abort[1]), .load(load[1]), .v_init(v_init[1]),
    .last_flag(last_flag[1]), .round(round[1]), .mode(mode[1]), .g_en(g_en[1]),
    .h_update(h_update[1]), .busy(busy[1]), .done(done[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nr(input int i);
    return (i == 0) ? 10 : 2;
  endfunction

  function automatic int gl(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic add_ev(input int i, input int k, input int c, input int r, input int m,
                        input int lf, input int cut, input bit by_reset);
    ev_t e;
    bit keep;
    if (cut < 0) keep = 1'b1;
    else if (k <= 1 || by_reset) keep = (c <= cut);
    else keep = (c < cut);
    if (keep) begin
      e.inst = i; e.kind = k; e.cyc = c; e.rnd = r; e.md = m; e.lf = lf;
      exp_q.push_back(e);
    end
  endtask

  // Reference schedule: every half-round k occupies G cycles, G-function commit on the last
  task automatic push_exp(input int i, input int t, input int lf, input int cut, input bit by_reset);
    int n = nr(i);
    int g = gl(i);
    int h = 2 * n * g;
    add_ev(i, 0, t + 1, 0, 0, lf, cut, by_reset);
    for (int k = 0; k < 2 * n; k++)
      add_ev(i, 1, t + 1 + (k + 1) * g, k / 2, k % 2, lf, cut, by_reset);
    add_ev(i, 2, t + 2 + h, 0, 0, lf, cut, by_reset);
    add_ev(i, 3, t + 3 + h, 0, 0, lf, cut, by_reset);
  endtask

  task automatic pop_check(input int i, input int k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_pulse: got inst=%0d kind=%0d cyc=%0d required no pulse", i, k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != i || e.kind != k || e.cyc != cyc || e.rnd != int'(round[i]) ||
          e.md != int'(mode[i]) || e.lf != int'(last_flag[i])) begin
        bad++;
        $display("FAIL event: got inst=%0d kind=%0d cyc=%0d round=%0d mode=%0d last=%0d required inst=%0d kind=%0d cyc=%0d round=%0d mode=%0d last=%0d",
                 i, k, cyc, round[i], mode[i], last_flag[i], e.inst, e.kind, e.cyc, e.rnd, e.md, e.lf);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        if (load[i])     pop_check(i, 0);
        if (g_en[i])     pop_check(i, 1);
        if (h_update[i]) pop_check(i, 2);
        if (done[i])     pop_check(i, 3);
        check("v_init_with_load", int'(v_init[i]), int'(load[i]));
        check("busy_not_ready", int'(busy[i]), int'(!blk_ready[i]));
      end
    end
  end

  task automatic check_idle(input int i, input string tag);
    check({tag, "_blk_ready"}, int'(blk_ready[i]), 1);
    check({tag, "_busy"}, int'(busy[i]), 0);
    check({tag, "_round"}, int'(round[i]), 0);
    check({tag, "_mode"}, int'(mode[i]), 0);
    check({tag, "_last_flag"}, int'(last_flag[i]), 0);
    check({tag, "_pulses"}, int'({load[i], v_init[i], g_en[i], h_update[i], done[i]}), 0);
  endtask

  // One block; abort_off/rst_off are cycle offsets from the accept (0 = none)
  task automatic run_block(input int i, input bit lf, input int abort_off, input int rst_off,
                           input bit abort_with_accept);
    int t = cyc;
    int h = 2 * nr(i) * gl(i);
    int cut = (abort_off > 0) ? t + abort_off : ((rst_off > 0) ? t + rst_off : -1);
    push_exp(i, t, int'(lf), cut, rst_off > 0);
    blk_valid[i] = 1'b1;
    blk_last[i]  = lf;
    abort[i]     = abort_with_accept;
    tick();
    blk_valid[i] = 1'b0;
    abort[i]     = 1'b0;
    for (int off = 1; off <= h + 3; off++) begin
      if (off == abort_off) begin
        abort[i] = 1'b1;
        tick();
        abort[i] = 1'b0;
        check_idle(i, "after_abort");
        check("abort_drained", exp_q.size(), 0);
        return;
      end
      if (off == rst_off) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_idle(i, "after_reset");
        check("reset_drained", exp_q.size(), 0);
        return;
      end
      tick();
    end
    check("block_ready_again", int'(blk_ready[i]), 1);
    check("block_drained", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    reset_n   = 1'b0;
    blk_valid = '0;
    blk_last  = '0;
    abort     = '0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", int'(busy[i]), 0);
      check("reset_round", int'(round[i]), 0);
      check("reset_last_flag", int'(last_flag[i]), 0);
      check("reset_pulses", int'({load[i], v_init[i], g_en[i], h_update[i], done[i]}), 0);
    end
    reset_n = 1'b1;
    tick();
    check("ready_after_reset0", int'(blk_ready[0]), 1);
    check("ready_after_reset1", int'(blk_ready[1]), 1);

    // default single block, then short/slow configuration
    run_block(0, 1'b1, 0, 0, 1'b0);
    run_block(1, 1'b1, 0, 0, 1'b0);
    run_block(1, 1'b0, 0, 0, 1'b0);

    // back-to-back with blk_valid held high; blk_last drops after the first accept
    t = cyc;
    push_exp(0, t, 1, -1, 1'b0);
    push_exp(0, t + 24, 0, -1, 1'b0);
    blk_valid[0] = 1'b1;
    blk_last[0]  = 1'b1;
    tick();
    blk_last[0] = 1'b0;
    repeat (23) tick();
    check("b2b_ready_at_T24", int'(blk_ready[0]), 1);
    tick();
    blk_valid[0] = 1'b0;
    check("b2b_busy_at_T25", int'(busy[0]), 1);
    repeat (23) tick();
    check("b2b_drained", exp_q.size(), 0);

    // abort during ROUND then immediate re-accept; abort during FINAL; reset mid-ROUND
    run_block(0, 1'b1, 7, 0, 1'b0);
    run_block(0, 1'b1, 0, 0, 1'b0);
    run_block(0, 1'b1, 22, 0, 1'b0);
    run_block(0, 1'b1, 0, 10, 1'b0);
    run_block(0, 1'b1, 0, 0, 1'b1);

    // abort while idle is ignored
    abort = 2'b11;
    repeat (2) tick();
    abort = 2'b00;
    check_idle(0, "idle_abort0");
    check_idle(1, "idle_abort1");

    for (int n = 0; n < 14; n++) begin
      int i  = int'($urandom_range(0, 1));
      int h  = 2 * nr(i) * gl(i);
      int sc = int'($urandom_range(0, 3));
      bit lf = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      case (sc)
        1:       run_block(i, lf, int'($urandom_range(1, h + 3)), 0, 1'b0);
        2:       run_block(i, lf, 0, 0, 1'b1);
        3:       run_block(i, lf, 0, int'($urandom_range(1, h + 3)), 1'b0);
        default: run_block(i, lf, 0, 0, 1'b0);
      endcase
    end

    repeat (4) tick();
    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
